// File: rtl/rv_pkg.sv
// Shared RV32 core definitions.
//   XLEN         - architectural register / PC width in bits.
//   RESET_VECTOR - default address the PC takes while reset is asserted.
//   ILEN_BYTES   - instruction length in bytes (no compressed ISA), used for PC+4.
package rv_pkg;

  localparam int                XLEN         = 32;
  localparam logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000;
  localparam int                ILEN_BYTES   = 4;

endpackage : rv_pkg

// File: rtl/program_counter.sv
// Architectural program-counter register for the single-cycle RV32 core.
// This is the only owner of the PC flop. The fetch/branch mux that produces
// PC_Nxt stays purely combinational elsewhere.
//
// Ports:
//   clk           in   1     system clock, PC updates on the rising edge
//   rst           in   1     asynchronous active-high reset, forces RESET_VECTOR
//   PC            out  XLEN  current program counter (registered)
//   PC_Nxt        in   XLEN  next PC, sampled on every rising clk edge
//   PC_Plus4      out  XLEN  combinational PC + 4, wraps modulo 2^XLEN
//   PC_Misaligned out  1     combinational, high when PC[ALIGN_BITS-1:0] != 0
module program_counter
  import rv_pkg::ILEN_BYTES;
#(
  parameter int              XLEN         = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(rv_pkg::RESET_VECTOR),
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] PC_Nxt,
  output logic [XLEN-1:0] PC_Plus4,
  output logic            PC_Misaligned
);

  // There is no enable and no stall. To hold the PC, the upstream mux feeds PC back.
  // NOTE: rst is in the sensitivity list so reset acts immediately. It is tested
  // first, so it wins over a simultaneous clock edge. Sequential state uses
  // non-blocking assignments to avoid simulation races with its readers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC <= RESET_VECTOR;
    end else begin
      PC <= PC_Nxt;
    end
  end

  // The carry out of the MSB is dropped on purpose: the top word wraps to 0.
  assign PC_Plus4 = PC + XLEN'(ILEN_BYTES);

  // The PC is stored bit-exact. Misaligned targets are only flagged here,
  // and the trap unit decides what to do with them.
  assign PC_Misaligned = |PC[ALIGN_BITS-1:0];

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter.
// The stimulus process drives directed vectors. For each one it pushes the
// hand-computed expected PC / PC_Plus4 / PC_Misaligned into a scoreboard
// queue and raises a sample event. A separate monitor process pops the queue
// and compares the entry against the DUT outputs present at that moment.
`timescale 1ns/1ps
module tb_program_counter;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] plus4;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_plus4;
  logic        pc_misaligned;
  logic        clk_en;

  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];
  event sample_ev;

  program_counter dut (
    .clk          (clk),
    .rst          (rst),
    .PC           (pc),
    .PC_Nxt       (pc_nxt),
    .PC_Plus4     (pc_plus4),
    .PC_Misaligned(pc_misaligned)
  );

  // Gated clock with a 10 ns period. It stays idle until clk_en is set, so
  // the bench can test reset with no clock activity at all.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples the DUT whenever the stimulus says an output is due.
  initial begin
    exp_t it;
    forever begin
      @(sample_ev);
      while (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        check({it.name, ".pc"},    pc,                   it.pc);
        check({it.name, ".plus4"}, pc_plus4,             it.plus4);
        check({it.name, ".mis"},   {31'd0, pc_misaligned}, {31'd0, it.mis});
      end
    end
  end

  // Push an expectation and let the monitor consume it before time moves on.
  task automatic expect_state(input string name, input logic [31:0] e_pc,
                              input logic [31:0] e_plus4, input logic e_mis);
    exp_t it;
    it.name  = name;
    it.pc    = e_pc;
    it.plus4 = e_plus4;
    it.mis   = e_mis;
    exp_q.push_back(it);
    -> sample_ev;
    #1;
  endtask

  // Advance to the next rising edge and settle 1 ns past it before sampling.
  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, expected to finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk      = 1'b0;
    clk_en   = 1'b0;
    rst      = 1'b0;
    pc_nxt   = 32'h0000_1234;

    // Reset with no clock at all: PC must go to the vector immediately.
    #1 rst = 1'b1;
    #1 expect_state("rst_noclk", 32'h0, 32'h4, 1'b0);

    // Release reset with no edge yet: PC keeps the vector.
    rst    = 1'b0;
    pc_nxt = 32'h0000_0002;
    #1 expect_state("rel_noedge", 32'h0, 32'h4, 1'b0);

    // Start the clock. PC_Nxt=2 is held for 100 periods; PC loads 2 on the
    // first edge and stays there.
    clk_en = 1'b1;
    rise();
    expect_state("load2_first", 32'h2, 32'h6, 1'b1);
    for (int i = 1; i < 100; i++) begin
      rise();
      if (i % 10 == 0) expect_state($sformatf("hold2_%0d", i), 32'h2, 32'h6, 1'b1);
    end

    // Assert reset between edges: PC clears before any edge.
    @(negedge clk);
    #1 rst = 1'b1;
    #1 expect_state("rst_mid", 32'h0, 32'h4, 1'b0);

    // Hold reset while PC_Nxt=3 and the clock runs: PC stays 0.
    pc_nxt = 32'h0000_0003;
    for (int i = 0; i < 3; i++) begin
      rise();
      expect_state($sformatf("rst_held_%0d", i), 32'h0, 32'h4, 1'b0);
    end

    // Release reset mid-cycle: PC holds 0 until the next rising edge, then loads 3.
    @(negedge clk);
    rst = 1'b0;
    #1 expect_state("rel_wait", 32'h0, 32'h4, 1'b0);
    rise();
    expect_state("load3", 32'h3, 32'h7, 1'b1);

    // Top-of-memory wrap followed by an ordinary aligned target.
    @(negedge clk);
    pc_nxt = 32'hFFFF_FFFC;
    rise();
    expect_state("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0);
    @(negedge clk);
    pc_nxt = 32'h0000_0010;
    rise();
    expect_state("load16", 32'h10, 32'h14, 1'b0);

    // A PC_Nxt change between edges (falling edge included) does not move PC.
    @(negedge clk);
    pc_nxt = 32'h8000_0001;
    #1 expect_state("nxt_between", 32'h10, 32'h14, 1'b0);
    @(posedge clk);
    #1 expect_state("bit0_mis", 32'h8000_0001, 32'h8000_0005, 1'b1);

    // Reset raised in the same timestep as a rising edge, with PC_Nxt=8: reset wins.
    @(negedge clk);
    pc_nxt = 32'h0000_0008;
    @(posedge clk);
    rst = 1'b1;
    #1 expect_state("rst_at_edge", 32'h0, 32'h4, 1'b0);

    // Release reset; the next edge loads 8.
    @(negedge clk);
    rst = 1'b0;
    rise();
    expect_state("load8", 32'h8, 32'hC, 1'b0);

    // Every expectation must have been consumed by the monitor.
    #2;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_program_counter
